serial_operand_streamer: RTL and testbench

//  Transmit side of the bit-serial compare interface. Accepts two WIDTH-bit operands

---
 rtl/serial_operand_streamer.sv | 142 ++++++++++++++
 tb/tb_serial_operand_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_streamer
// Description : Accepts an operand pair over valid/ready and streams the pair
//               MSB-first on x/y. The comparator is cleared before each frame.
//               STREAMER_RESULT_CAPTURE_EN enables capture of comparator results.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_streamer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_reset,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done
`ifdef STREAMER_RESULT_CAPTURE_EN
  ,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_valid
`endif
);

  localparam int C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_sa;
  logic [WIDTH-1:0]     r_sb;
  logic [WIDTH-1:0]     w_sa_shl;
  logic [WIDTH-1:0]     w_sb_shl;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_x;
  logic                 r_y;
  logic                 w_accept;

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept  = in_ready && in_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign cmp_reset = reset || (r_state == S_CLR);
  assign x         = r_x;
  assign y         = r_y;
  assign w_sa_shl  = r_sa << 1;
  assign w_sb_shl  = r_sb << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // x/y are registered one cycle ahead: the bit presented next is loaded here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x   <= 1'b0;
      r_y   <= 1'b0;
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
    end else begin
      r_x <= 1'b0;
      r_y <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_cnt <= C_CNT_W'(WIDTH - 1);
          end
        end
        S_CLR: begin
          r_x <= r_sa[WIDTH-1];
          r_y <= r_sb[WIDTH-1];
        end
        S_SHIFT: begin
          r_sa  <= w_sa_shl;
          r_sb  <= w_sb_shl;
          r_cnt <= r_cnt - C_CNT_W'(1);
          if (r_cnt != '0) begin
            r_x <= w_sa_shl[WIDTH-1];
            r_y <= w_sb_shl[WIDTH-1];
          end
        end
        default: begin
          r_x <= 1'b0;
          r_y <= 1'b0;
        end
      endcase
    end
  end

`ifdef STREAMER_RESULT_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      res_gt    <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      res_valid <= 1'b0;
    end else if (w_accept) begin
      res_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      res_gt    <= cmp_gt;
      res_lt    <= cmp_lt;
      res_eq    <= ~cmp_gt & ~cmp_lt;
      res_valid <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_operand_streamer
// Description : Directed self-checking bench for serial_operand_streamer
//               (WIDTH=8 and WIDTH=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_operand_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_ready, cmp_reset, x, y, busy, done;

  logic       v1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       rdy1, cr1, x1, y1, busy1, done1;

`ifdef STREAMER_RESULT_CAPTURE_EN
  logic gt, lt;
  logic res_gt, res_lt, res_eq, res_valid;
  logic r1_gt, r1_lt, r1_eq, r1_valid;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_operand_streamer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cmp_reset(cmp_reset), .x(x), .y(y), .busy(busy), .done(done)
`ifdef STREAMER_RESULT_CAPTURE_EN
    , .cmp_gt(gt), .cmp_lt(lt), .res_gt(res_gt), .res_lt(res_lt),
    .res_eq(res_eq), .res_valid(res_valid)
`endif
  );

  serial_operand_streamer #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
    .a(a1), .b(b1), .cmp_reset(cr1), .x(x1), .y(y1), .busy(busy1), .done(done1)
`ifdef STREAMER_RESULT_CAPTURE_EN
    , .cmp_gt(1'b0), .cmp_lt(1'b0), .res_gt(r1_gt), .res_lt(r1_lt),
    .res_eq(r1_eq), .res_valid(r1_valid)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the cycle after the accepting edge; leaves in the first idle cycle.
  task automatic frame(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    chk({tag, "_clr"}, cmp_reset, 1);
    chk({tag, "_clr_busy"}, busy, 1);
    chk({tag, "_clr_rdy"}, in_ready, 0);
    chk({tag, "_clr_x"}, x, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_x%0d", tag, i), x, ea[7-i]);
      chk($sformatf("%s_y%0d", tag, i), y, eb[7-i]);
      chk($sformatf("%s_cr%0d", tag, i), cmp_reset, 0);
      chk($sformatf("%s_rdy%0d", tag, i), in_ready, 0);
      chk($sformatf("%s_dn%0d", tag, i), done, 0);
      tick();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_x"}, x, 0);
    chk({tag, "_done_busy"}, busy, 1);
    tick();
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
`ifdef STREAMER_RESULT_CAPTURE_EN
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_gt"}, res_gt, (ea > eb));
    chk({tag, "_res_lt"}, res_lt, (ea < eb));
    chk({tag, "_res_eq"}, res_eq, (ea == eb));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, done_n, consec, last_acc, k;
    logic prev_done;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    v1 = 1'b0; a1 = '0; b1 = '0;
`ifdef STREAMER_RESULT_CAPTURE_EN
    gt = 1'b0; lt = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_rdy", in_ready, 0);
    chk("rst_cmp_reset", cmp_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    reset = 1'b0;
    tick();
    chk("rel_rdy", in_ready, 1);
    chk("rel_cmp_reset", cmp_reset, 0);

    // Test 1: A5 vs 5A
    a = 8'hA5; b = 8'h5A; in_valid = 1'b1;
`ifdef STREAMER_RESULT_CAPTURE_EN
    gt = 1'b1; lt = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    frame("t1", 8'hA5, 8'h5A);

    // Test 3: in_valid held; second pair accepted as soon as idle
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
`ifdef STREAMER_RESULT_CAPTURE_EN
    gt = 1'b0; lt = 1'b1;
`endif
    tick();
    a = 8'h01; b = 8'h80;
    frame("t3a", 8'h11, 8'h22);
    tick();
    in_valid = 1'b0;
    frame("t3b", 8'h01, 8'h80);

    // Test 4: reset during the 4th SHIFT cycle
    a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
`ifdef STREAMER_RESULT_CAPTURE_EN
    gt = 1'b1; lt = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("t4_mid_x", x, 1);
    chk("t4_mid_y", y, 0);
    reset = 1'b1;
    #1;
    chk("t4_rst_cr", cmp_reset, 1);
    chk("t4_rst_rdy", in_ready, 0);
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_x", x, 0);
    chk("t4_y", y, 0);
    chk("t4_done", done, 0);
    chk("t4_cr_held", cmp_reset, 1);
`ifdef STREAMER_RESULT_CAPTURE_EN
    chk("t4_res_valid", res_valid, 0);
`endif
    reset = 1'b0;
    #1;
    chk("t4_rel_cr", cmp_reset, 0);
    chk("t4_rel_rdy", in_ready, 1);
    tick();
    chk("t4_no_done", done, 0);

    // Test 2: equal operands, accepted after the aborted frame
    a = 8'h3C; b = 8'h3C; in_valid = 1'b1;
`ifdef STREAMER_RESULT_CAPTURE_EN
    gt = 1'b0; lt = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    frame("t2", 8'h3C, 8'h3C);

    // Test 5: in_valid held for 30 cycles
    a = 8'hC3; b = 8'hC3; in_valid = 1'b1;
    acc_n = 0; done_n = 0; consec = 0; last_acc = 0; prev_done = 1'b0;
    for (k = 0; k < 30; k++) begin
      if (in_valid && in_ready) begin
        if (acc_n > 0) chk("t5_interval", k - last_acc, 11);
        last_acc = k;
        acc_n++;
      end
      if (done && prev_done) consec++;
      if (done) done_n++;
      prev_done = done;
      tick();
    end
    in_valid = 1'b0;
    chk("t5_accepts", acc_n, 3);
    chk("t5_dones", done_n, 2);
    chk("t5_consec_done", consec, 0);
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("t5_drain", busy, 0);

    // Test 6: WIDTH=1 instance
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    #1;
    chk("t6_rdy", rdy1, 1);
    tick();
    v1 = 1'b0;
    chk("t6_clr", cr1, 1);
    chk("t6_clr_x", x1, 0);
    tick();
    chk("t6_x", x1, 1);
    chk("t6_y", y1, 0);
    chk("t6_nodone", done1, 0);
    tick();
    chk("t6_done", done1, 1);
    chk("t6_done_x", x1, 0);
    tick();
    chk("t6_done_end", done1, 0);
    chk("t6_idle", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
